// File: rtl/alu_issue_sequencer_if.sv
// +--------------------------------------------------------------------------+
// | alu_issue_sequencer_if: decoder, ALU, write-back and debug signal bundle |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

interface alu_issue_sequencer_if #(
  parameter int WORD_SIZE   = 16,
  parameter int OPCODE_SIZE = 5,
  parameter int REG_ADDR_W  = 3
);
  logic                   in_valid;
  logic                   in_ready;
  logic [OPCODE_SIZE-1:0] in_opcode;
  logic [REG_ADDR_W-1:0]  in_rd;
  logic [REG_ADDR_W-1:0]  in_rs1;
  logic [REG_ADDR_W-1:0]  in_rs2;
  logic [WORD_SIZE-1:0]   in_imm;
  logic [OPCODE_SIZE-1:0] alu_opcode;
  logic [WORD_SIZE-1:0]   alu_input1;
  logic [WORD_SIZE-1:0]   alu_input2;
  logic                   alu_enable;
  logic [WORD_SIZE-1:0]   alu_out;
  logic                   wb_valid;
  logic [REG_ADDR_W-1:0]  wb_rd;
  logic [WORD_SIZE-1:0]   wb_data;
  logic [REG_ADDR_W-1:0]  dbg_addr;
  logic [WORD_SIZE-1:0]   dbg_data;

  // master = decoder/ALU/debug environment, slave = the sequencer
  modport master (
    output in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_imm, alu_out, dbg_addr,
    input  in_ready, alu_opcode, alu_input1, alu_input2, alu_enable,
           wb_valid, wb_rd, wb_data, dbg_data
  );

  modport slave (
    input  in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_imm, alu_out, dbg_addr,
    output in_ready, alu_opcode, alu_input1, alu_input2, alu_enable,
           wb_valid, wb_rd, wb_data, dbg_data
  );
endinterface

`default_nettype wire

// File: rtl/alu_issue_sequencer.sv
// +--------------------------------------------------------------------------+
// | alu_issue_sequencer: serial issue stage, regfile read, ALU issue, writeback|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module alu_issue_sequencer #(
  parameter int                     WORD_SIZE   = 16,
  parameter int                     OPCODE_SIZE = 5,
  parameter int                     REG_ADDR_W  = 3,
  parameter logic [OPCODE_SIZE-1:0] ADDI_OPCODE = OPCODE_SIZE'(1),
  parameter logic [OPCODE_SIZE-1:0] ANDI_OPCODE = OPCODE_SIZE'(3)
) (
  input  wire logic          clock,
  input  wire logic          reset_n,
  alu_issue_sequencer_if.slave bus
);

  localparam int NUM_REGS = 1 << REG_ADDR_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    RESULT = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [OPCODE_SIZE-1:0] opcode_q, opcode_d;
  logic [WORD_SIZE-1:0]   input1_q, input1_d;
  logic [WORD_SIZE-1:0]   input2_q, input2_d;
  logic [REG_ADDR_W-1:0]  rd_q, rd_d;
  logic [WORD_SIZE-1:0]   regs_q [NUM_REGS];
  logic [WORD_SIZE-1:0]   regs_d [NUM_REGS];
  logic                   use_imm;

  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    input1_d = input1_q;
    input2_d = input2_q;
    rd_d     = rd_q;
    regs_d   = regs_q;
    use_imm  = (bus.in_opcode == ADDI_OPCODE) || (bus.in_opcode == ANDI_OPCODE);

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          state_d  = ISSUE;
          opcode_d = bus.in_opcode;
          rd_d     = bus.in_rd;
          input1_d = regs_q[bus.in_rs1];
          input2_d = use_imm ? bus.in_imm : regs_q[bus.in_rs2];
        end
      end
      ISSUE: begin
        state_d = RESULT;
      end
      RESULT: begin
        state_d = IDLE;
        // Entry 0 is never written, so it reads back as zero forever
        if (rd_q != '0) begin
          regs_d[rd_q] = bus.alu_out;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      opcode_q <= '0;
      input1_q <= '0;
      input2_q <= '0;
      rd_q     <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      input1_q <= input1_d;
      input2_q <= input2_d;
      rd_q     <= rd_d;
      regs_q   <= regs_d;
    end
  end

  // Handshake and strobes decode from state only; no path from in_valid
  assign bus.in_ready   = (state_q == IDLE);
  assign bus.alu_enable = (state_q == ISSUE);
  assign bus.wb_valid   = (state_q == RESULT);
  assign bus.wb_rd      = rd_q;
  assign bus.wb_data    = (state_q == RESULT) ? bus.alu_out : '0;
  assign bus.alu_opcode = opcode_q;
  assign bus.alu_input1 = input1_q;
  assign bus.alu_input2 = input2_q;
  assign bus.dbg_data   = regs_q[bus.dbg_addr];

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_sequencer.sv
// +--------------------------------------------------------------------------+
// | tb_alu_issue_sequencer: directed vectors with queue-based scoreboard     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_alu_issue_sequencer;

  localparam logic [4:0] OP_ADD  = 5'h00;
  localparam logic [4:0] OP_ADDI = 5'h01;
  localparam logic [4:0] OP_AND  = 5'h02;
  localparam logic [4:0] OP_ANDI = 5'h03;
  localparam logic [4:0] OP_UNK  = 5'h1F;

  logic clock;
  logic reset_n;

  alu_issue_sequencer_if #(.WORD_SIZE(16), .OPCODE_SIZE(5), .REG_ADDR_W(3)) bus ();

  alu_issue_sequencer #(
    .WORD_SIZE  (16),
    .OPCODE_SIZE(5),
    .REG_ADDR_W (3),
    .ADDI_OPCODE(OP_ADDI),
    .ANDI_OPCODE(OP_ANDI)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus.slave)
  );

  int checks   = 0;
  int failures = 0;
  int wb_count = 0;

  logic [36:0] exp_op_q [$];  // {opcode, input1, input2}
  logic [18:0] exp_wb_q [$];  // {rd, data}

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Registered ALU model: result appears the cycle after alu_enable
  initial bus.alu_out = '0;
  always @(posedge clock) begin
    if (bus.alu_enable) begin
      case (bus.alu_opcode)
        OP_ADD, OP_ADDI: bus.alu_out <= bus.alu_input1 + bus.alu_input2;
        OP_AND, OP_ANDI: bus.alu_out <= bus.alu_input1 & bus.alu_input2;
        default:         bus.alu_out <= '0;
      endcase
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents an issue or a write-back
  always @(negedge clock) begin
    if (reset_n && bus.alu_enable) begin
      if (exp_op_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL alu_enable_unexpected: got 1 expected 0");
      end else begin
        logic [36:0] e;
        e = exp_op_q.pop_front();
        check("alu_opcode", 32'(bus.alu_opcode), 32'(e[36:32]));
        check("alu_input1", 32'(bus.alu_input1), 32'(e[31:16]));
        check("alu_input2", 32'(bus.alu_input2), 32'(e[15:0]));
      end
    end
    if (reset_n && bus.wb_valid) begin
      wb_count++;
      if (exp_wb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL wb_valid_unexpected: got 1 expected 0");
      end else begin
        logic [18:0] w;
        w = exp_wb_q.pop_front();
        check("wb_rd",   32'(bus.wb_rd),   32'(w[18:16]));
        check("wb_data", 32'(bus.wb_data), 32'(w[15:0]));
      end
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (!bus.in_ready) check("wait_ready_timeout", 32'(bus.in_ready), 32'd1);
  endtask

  task automatic count_busy(input string name);
    int low;
    low = 0;
    @(negedge clock);
    while (!bus.in_ready && low < 10) begin
      low++;
      @(negedge clock);
    end
    check(name, 32'(low), 32'd2);
  endtask

  task automatic issue(input logic [4:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                       input logic [2:0] rs2, input logic [15:0] imm,
                       input logic [15:0] e1, input logic [15:0] e2, input logic [15:0] ewb);
    exp_op_q.push_back({op, e1, e2});
    exp_wb_q.push_back({rd, ewb});
    bus.in_opcode = op;
    bus.in_rd     = rd;
    bus.in_rs1    = rs1;
    bus.in_rs2    = rs2;
    bus.in_imm    = imm;
    bus.in_valid  = 1'b1;
    wait_ready();
    @(posedge clock);
    #1 bus.in_valid = 1'b0;
    count_busy("in_ready_low_cycles");
  endtask

  task automatic dbg_chk(input logic [2:0] addr, input logic [15:0] exp);
    bus.dbg_addr = addr;
    #1;
    check($sformatf("dbg_r%0d", addr), 32'(bus.dbg_data), 32'(exp));
  endtask

  initial begin
    reset_n       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_opcode = '0;
    bus.in_rd     = '0;
    bus.in_rs1    = '0;
    bus.in_rs2    = '0;
    bus.in_imm    = '0;
    bus.dbg_addr  = '0;

    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    @(negedge clock);
    check("rst_in_ready",   32'(bus.in_ready),   32'd1);
    check("rst_alu_enable", 32'(bus.alu_enable), 32'd0);
    check("rst_wb_valid",   32'(bus.wb_valid),   32'd0);
    check("rst_wb_rd",      32'(bus.wb_rd),      32'd0);
    check("rst_wb_data",    32'(bus.wb_data),    32'd0);
    check("rst_alu_opcode", 32'(bus.alu_opcode), 32'd0);
    check("rst_alu_input1", 32'(bus.alu_input1), 32'd0);
    check("rst_alu_input2", 32'(bus.alu_input2), 32'd0);
    for (int a = 0; a < 8; a++) dbg_chk(3'(a), 16'h0000);

    // Immediate path
    issue(OP_ADDI, 3'd1, 3'd0, 3'd0, 16'h0005, 16'h0000, 16'h0005, 16'h0005);
    dbg_chk(3'd1, 16'h0005);

    // Dependent back-to-back chain
    issue(OP_ADD,  3'd2, 3'd1, 3'd1, 16'h0000, 16'h0005, 16'h0005, 16'h000A);
    issue(OP_ANDI, 3'd3, 3'd2, 3'd0, 16'h000C, 16'h000A, 16'h000C, 16'h0008);
    dbg_chk(3'd2, 16'h000A);
    dbg_chk(3'd3, 16'h0008);

    // Register 0 write is dropped but still reported
    issue(OP_ADDI, 3'd0, 3'd0, 3'd0, 16'hFFFF, 16'h0000, 16'hFFFF, 16'hFFFF);
    dbg_chk(3'd0, 16'h0000);

    // Unknown opcode forwards R[rs2] and writes back zero
    issue(OP_ADDI, 3'd5, 3'd3, 3'd0, 16'h0003, 16'h0008, 16'h0003, 16'h000B);
    dbg_chk(3'd5, 16'h000B);
    issue(OP_UNK,  3'd5, 3'd5, 3'd1, 16'h1234, 16'h000B, 16'h0005, 16'h0000);
    dbg_chk(3'd5, 16'h0000);

    // Backpressure: second instruction held valid while busy, rd wiggles before acceptance
    exp_op_q.push_back({OP_ADDI, 16'h0005, 16'h0009});
    exp_wb_q.push_back({3'd6, 16'h000E});
    exp_op_q.push_back({OP_ADDI, 16'h000E, 16'h0001});
    exp_wb_q.push_back({3'd7, 16'h000F});
    bus.in_opcode = OP_ADDI;
    bus.in_rd     = 3'd6;
    bus.in_rs1    = 3'd1;
    bus.in_imm    = 16'h0009;
    bus.in_valid  = 1'b1;
    wait_ready();
    @(posedge clock);
    #1;
    bus.in_rd  = 3'd3;
    bus.in_rs1 = 3'd6;
    bus.in_imm = 16'h0001;
    @(posedge clock);
    #1 bus.in_rd = 3'd7;
    wait_ready();
    @(posedge clock);
    #1 bus.in_valid = 1'b0;
    count_busy("bp_in_ready_low_cycles");
    dbg_chk(3'd6, 16'h000E);
    dbg_chk(3'd7, 16'h000F);
    dbg_chk(3'd3, 16'h0008);

    // Reset asserted during RESULT aborts the write-back
    exp_op_q.push_back({OP_ADDI, 16'h0000, 16'h0007});
    bus.in_opcode = OP_ADDI;
    bus.in_rd     = 3'd4;
    bus.in_rs1    = 3'd0;
    bus.in_imm    = 16'h0007;
    bus.in_valid  = 1'b1;
    wait_ready();
    @(posedge clock);
    #1 bus.in_valid = 1'b0;
    @(posedge clock);
    #1 reset_n = 1'b0;
    @(posedge clock);
    #1 reset_n = 1'b1;
    @(negedge clock);
    check("midrst_wb_valid",   32'(bus.wb_valid),   32'd0);
    check("midrst_in_ready",   32'(bus.in_ready),   32'd1);
    check("midrst_alu_input2", 32'(bus.alu_input2), 32'd0);
    dbg_chk(3'd4, 16'h0000);
    dbg_chk(3'd1, 16'h0000);

    repeat (3) @(negedge clock);
    check("wb_pulse_count", 32'(wb_count),        32'd8);
    check("op_queue_empty", 32'(exp_op_q.size()), 32'd0);
    check("wb_queue_empty", 32'(exp_wb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
